vga_data_req_gen: RTL and testbench
===================================

Name: vga_data_req_gen

Overview:
- Parametrised successor to the VGA pixel-address change detector.
- Watches the VGA controller's pixel address, detects changes and line wrap, and decimates change events by a programmable ratio.
- Issues read requests to the frame/line buffer in one of two modes: single-cycle pulse, or request/acknowledge with a small address queue.
- Sits between the VGA timing controller and the SDRAM/line-buffer read port of the CCD capture path.

Parameters:
- ADDR_W, 10, width of the pixel address.
- DIV, 1, issue one request per DIV address-change events (DIV >= 1).
- HANDSHAKE, 0, 0 = pulse mode, 1 = request/acknowledge queued mode.
- DEPTH, 4, address-queue depth in handshake mode (power of 2, >= 2).

Ports:
- iCLK  in  1  clock; all logic on rising edge.
- iRST  in  1  reset; synchronous, active-high.
- iEN  in  1  event enable; low suppresses new events.
- iADDR  in  ADDR_W  current pixel address from the VGA controller.
- iACK  in  1  consumer accepts the head request (handshake mode only).
- iCLR_OVF  in  1  clears the sticky overflow flag.
- oREQ  out  1  read request.
- oREQ_ADDR  out  ADDR_W  address associated with oREQ.
- oLINE_START  out  1  one-cycle pulse on address wrap (new line).
- oPEND  out  clog2(DEPTH)+1  queued request count; 0 in pulse mode.
- oOVF  out  1  sticky: a request was dropped because the queue was full.

Behaviour:
- Reset (iRST=1 at a clock edge): pre_addr=0, div_cnt=0, queue empty, oREQ=0, oREQ_ADDR=0, oLINE_START=0, oPEND=0, oOVF=0.
- pre_addr <= iADDR every cycle regardless of iEN, so re-enabling never produces a stale event.
- Change event: evt = iEN & (iADDR != pre_addr). After reset, the first nonzero address therefore produces an event.
- Wrap: wrap = evt & (iADDR < pre_addr), unsigned compare.
- Decimation, applied when evt:
  - req_evt = wrap | (div_cnt == 0).
  - div_cnt <= wrap ? (1 mod DIV) : ((div_cnt+1) mod DIV).
  - DIV=1: every event requests.
  - A wrap always requests and re-phases the decimator to the line start.
- oLINE_START is registered and equals wrap one edge late. It is independent of DIV and present in both modes.
- Pulse mode (HANDSHAKE=0):
  - Registered: oREQ <= req_evt. On req_evt, oREQ_ADDR <= iADDR; otherwise it holds.
  - Latency: iADDR changes before edge k, so oREQ is high for exactly the cycle after edge k.
  - A steady address gives oREQ=0. iACK is ignored; oPEND=0 and oOVF=0 permanently.
- Handshake mode (HANDSHAKE=1):
  - Queue is a FIFO of DEPTH addresses with a count register.
  - push = req_evt (data = iADDR); pop = iACK & oREQ.
  - oREQ = (count != 0); oREQ_ADDR = head entry; oPEND = count. All are driven from registers.
  - oREQ_ADDR holds its value while oREQ=1 and iACK=0.
  - Push only: count+1. Pop only: count-1. Push and pop together: count unchanged; head advances and the new entry is written.
  - Push while full without pop: entry dropped, count unchanged, oOVF <= 1.
  - Push while full with pop: accepted, no overflow.
  - iACK while empty: ignored.
  - A push into an empty queue appears as oREQ=1 the cycle after the push edge. Same 1-cycle latency as pulse mode.
  - Pointers wrap modulo DEPTH.
- oOVF: a set in the same cycle as iCLR_OVF wins. Otherwise iCLR_OVF clears the flag.
- iEN=0: no evt, req_evt or wrap; div_cnt holds; the queue still drains via iACK.
- iRST mid-operation: queue discarded, all state returns to reset values on that edge.

Test Plan:
- Pulse, DIV=1: iADDR 0→5→6→6→7, one step per cycle → oREQ pulses after the 5, 6 and 7 edges, none for the repeated 6. oREQ_ADDR = 5, 6, 7.
- Pulse, DIV=3: iADDR 1..10 incrementing, then 0 → requests at addresses 1, 4, 7, 10, then 0 (wrap). oLINE_START=1 only on the cycle after the 0.
- iEN gating: iEN=0 while iADDR steps 3→4→5, then iEN=1 with iADDR held at 5 → no oREQ at all. Next change 5→6 → single oREQ at 6.
- Handshake, DEPTH=4, iACK=0: addresses 1..5 → oPEND 1,2,3,4,4; oOVF=1 after the 5th; oREQ_ADDR=1 throughout. Then iACK=1 for 4 cycles → oREQ_ADDR 1,2,3,4; oPEND 3,2,1,0; oREQ drops.
- Handshake, queue full with iACK=1 and a new change in the same cycle → oPEND stays 4, oOVF stays 0, head advances to the next entry. iCLR_OVF asserted together with an overflowing push → oOVF=1.
- Reset mid-queue: oPEND=3, assert iRST for one cycle → oREQ=0, oPEND=0, oOVF=0, oREQ_ADDR=0. Next address change requests normally.

Source files
------------

// File: rtl/vga_data_req_gen_if.sv
// vga_data_req_gen_if
//   Groups the pixel-address input side and the read-request side of
//   vga_data_req_gen into one bundle.
//   Ports (signals):
//     iEN          event enable; low suppresses new change events
//     iADDR        current pixel address from the VGA timing controller
//     iACK         consumer accepts the head request (queued mode)
//     iCLR_OVF     clears the sticky overflow flag
//     oREQ         read request
//     oREQ_ADDR    address associated with oREQ
//     oLINE_START  one-cycle pulse on address wrap (new line)
//     oPEND        number of queued requests (0 in pulse mode)
//     oOVF         sticky: a request was dropped on a full queue
//   Modports:
//     master  the request generator (drives the o* signals)
//     slave   the surrounding system / read port (drives the i* signals)
interface vga_data_req_gen_if #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 4
);
  localparam int PEND_W = $clog2(DEPTH) + 1;

  logic              iEN;
  logic [ADDR_W-1:0] iADDR;
  logic              iACK;
  logic              iCLR_OVF;
  logic              oREQ;
  logic [ADDR_W-1:0] oREQ_ADDR;
  logic              oLINE_START;
  logic [PEND_W-1:0] oPEND;
  logic              oOVF;

  modport master (
    input  iEN, iADDR, iACK, iCLR_OVF,
    output oREQ, oREQ_ADDR, oLINE_START, oPEND, oOVF
  );

  modport slave (
    output iEN, iADDR, iACK, iCLR_OVF,
    input  oREQ, oREQ_ADDR, oLINE_START, oPEND, oOVF
  );
endinterface

// File: rtl/vga_data_req_gen.sv
// vga_data_req_gen
//   Watches the VGA controller's pixel address, detects address changes and
//   line wrap, decimates change events by DIV and issues frame/line-buffer
//   read requests either as single-cycle pulses (HANDSHAKE=0) or through a
//   small request/acknowledge address queue (HANDSHAKE=1).
//   Ports:
//     iCLK  clock, all logic on the rising edge
//     iRST  synchronous active-high reset
//     bus   vga_data_req_gen_if.master (address in, request out)
module vga_data_req_gen #(
  parameter int ADDR_W    = 10,
  parameter int DIV       = 1,
  parameter int HANDSHAKE = 0,
  parameter int DEPTH     = 4
) (
  input  logic               iCLK,
  input  logic               iRST,
  vga_data_req_gen_if.master bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  // Last decimator phase, and the phase a wrap re-starts from (1 mod DIV).
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] DIV_WRAP = DIV_W'((DIV > 1) ? 1 : 0);

  logic [ADDR_W-1:0] preAddr_r;
  logic [DIV_W-1:0]  divCnt_r;
  logic              lineStart_r;

  logic              evt_s;
  logic              wrap_s;
  logic              reqEvt_s;
  logic [DIV_W-1:0]  divNext_s;

  // Change/wrap detection and the decimation decision for this cycle
  always_comb begin
    evt_s    = bus.iEN & (bus.iADDR != preAddr_r);
    wrap_s   = evt_s & (bus.iADDR < preAddr_r);
    // A wrap always requests so every line starts with a request.
    reqEvt_s = evt_s & (wrap_s | (divCnt_r == '0));
    if (wrap_s) begin
      divNext_s = DIV_WRAP;
    end else if (divCnt_r == DIV_LAST) begin
      divNext_s = '0;
    end else begin
      divNext_s = divCnt_r + DIV_W'(1);
    end
  end

  // Previous-address tracker, decimator phase and line-start pulse
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      preAddr_r   <= '0;
      divCnt_r    <= '0;
      lineStart_r <= 1'b0;
    end else begin
      // Tracked even while disabled so re-enabling never sees a stale change.
      preAddr_r   <= bus.iADDR;
      lineStart_r <= wrap_s;
      if (evt_s) begin
        divCnt_r <= divNext_s;
      end
    end
  end

  assign bus.oLINE_START = lineStart_r;

  generate
    if (HANDSHAKE == 0) begin : gPulse
      logic              req_r;
      logic [ADDR_W-1:0] reqAddr_r;

      // One-cycle request pulse; the address holds between requests
      always_ff @(posedge iCLK) begin
        if (iRST) begin
          req_r     <= 1'b0;
          reqAddr_r <= '0;
        end else begin
          req_r <= reqEvt_s;
          if (reqEvt_s) begin
            reqAddr_r <= bus.iADDR;
          end
        end
      end

      assign bus.oREQ      = req_r;
      assign bus.oREQ_ADDR = reqAddr_r;
      assign bus.oPEND     = '0;
      assign bus.oOVF      = 1'b0;
    end else begin : gQueue
      logic [ADDR_W-1:0] mem_r [DEPTH];
      logic [PTR_W-1:0]  wrPtr_r;
      logic [PTR_W-1:0]  rdPtr_r;
      logic [CNT_W-1:0]  count_r;
      logic              req_r;
      logic [ADDR_W-1:0] head_r;
      logic              ovf_r;

      logic              pop_s;
      logic              full_s;
      logic              pushOk_s;
      logic              drop_s;
      logic [CNT_W-1:0]  countNext_s;
      logic [PTR_W-1:0]  rdPtrNext_s;
      logic [ADDR_W-1:0] headNext_s;

      // Queue control: accept/drop decision, next count and next head value
      always_comb begin
        pop_s    = bus.iACK & req_r;
        full_s   = (count_r == CNT_W'(DEPTH));
        // A full queue still accepts when the head leaves in the same cycle.
        pushOk_s = reqEvt_s & (~full_s | pop_s);
        drop_s   = reqEvt_s & full_s & ~pop_s;
        case ({pushOk_s, pop_s})
          2'b10:   countNext_s = count_r + CNT_W'(1);
          2'b01:   countNext_s = count_r - CNT_W'(1);
          default: countNext_s = count_r;
        endcase
        if (pop_s) begin
          rdPtrNext_s = rdPtr_r + PTR_W'(1);
        end else begin
          rdPtrNext_s = rdPtr_r;
        end
        // Head is registered, so forward the entry being written when it
        // lands exactly in the next head slot (empty queue or last entry popped).
        if (pushOk_s && (wrPtr_r == rdPtrNext_s)) begin
          headNext_s = bus.iADDR;
        end else begin
          headNext_s = mem_r[rdPtrNext_s];
        end
      end

      // Queue storage, pointers, count, registered head and sticky overflow
      always_ff @(posedge iCLK) begin
        if (iRST) begin
          for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
          end
          wrPtr_r <= '0;
          rdPtr_r <= '0;
          count_r <= '0;
          req_r   <= 1'b0;
          head_r  <= '0;
          ovf_r   <= 1'b0;
        end else begin
          if (pushOk_s) begin
            mem_r[wrPtr_r] <= bus.iADDR;
            wrPtr_r        <= wrPtr_r + PTR_W'(1);
          end
          rdPtr_r <= rdPtrNext_s;
          count_r <= countNext_s;
          req_r   <= (countNext_s != '0);
          head_r  <= headNext_s;
          // A drop in the same cycle as a clear leaves the flag set.
          if (drop_s) begin
            ovf_r <= 1'b1;
          end else if (bus.iCLR_OVF) begin
            ovf_r <= 1'b0;
          end
        end
      end

      assign bus.oREQ      = req_r;
      assign bus.oREQ_ADDR = head_r;
      assign bus.oPEND     = count_r;
      assign bus.oOVF      = ovf_r;
    end
  endgenerate
endmodule

// File: tb/tb_vga_data_req_gen.sv
// tb_vga_data_req_gen
//   Three instances: pulse DIV=1 (u0), pulse DIV=3 (u1), queued DEPTH=4 (u2).
//   Stimulus pushes expected request addresses into per-instance queues; a
//   negedge monitor pops and compares whenever a request is presented/taken.
module tb_vga_data_req_gen;
  typedef struct {
    logic [9:0] addr;
    logic       en;
    logic       req;
    logic       ls;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [9:0] exp0[$];
  logic [9:0] exp1[$];
  logic [9:0] expLs1[$];
  logic [9:0] exp2[$];

  vga_data_req_gen_if #(.ADDR_W(10), .DEPTH(4)) b0();
  vga_data_req_gen_if #(.ADDR_W(10), .DEPTH(4)) b1();
  vga_data_req_gen_if #(.ADDR_W(10), .DEPTH(4)) b2();

  vga_data_req_gen #(.ADDR_W(10), .DIV(1), .HANDSHAKE(0), .DEPTH(4)) u0 (
    .iCLK(clk), .iRST(rst), .bus(b0)
  );
  vga_data_req_gen #(.ADDR_W(10), .DIV(3), .HANDSHAKE(0), .DEPTH(4)) u1 (
    .iCLK(clk), .iRST(rst), .bus(b1)
  );
  vga_data_req_gen #(.ADDR_W(10), .DIV(1), .HANDSHAKE(1), .DEPTH(4)) u2 (
    .iCLK(clk), .iRST(rst), .bus(b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Scoreboard monitor: compares whenever a request is presented (pulse) or taken (queued)
  always @(negedge clk) begin
    if (b0.oREQ) begin
      if (exp0.size() == 0) chk("u0 spurious oREQ", 32'(b0.oREQ), 32'd0);
      else chk("u0 oREQ_ADDR", 32'(b0.oREQ_ADDR), 32'(exp0.pop_front()));
    end
    if (b0.oLINE_START) chk("u0 spurious oLINE_START", 32'(b0.oLINE_START), 32'd0);
    if (b1.oREQ) begin
      if (exp1.size() == 0) chk("u1 spurious oREQ", 32'(b1.oREQ), 32'd0);
      else chk("u1 oREQ_ADDR", 32'(b1.oREQ_ADDR), 32'(exp1.pop_front()));
    end
    if (b1.oLINE_START) begin
      if (expLs1.size() == 0) chk("u1 spurious oLINE_START", 32'(b1.oLINE_START), 32'd0);
      else chk("u1 line-start addr", 32'(b1.oREQ_ADDR), 32'(expLs1.pop_front()));
    end
    if (b2.oREQ && b2.iACK) begin
      if (exp2.size() == 0) chk("u2 spurious pop", 32'(b2.oREQ), 32'd0);
      else chk("u2 head at pop", 32'(b2.oREQ_ADDR), 32'(exp2.pop_front()));
    end
  end

  task automatic pulseVec(input int which, input vec_t v);
    if (which == 0) begin
      b0.iADDR = v.addr;
      b0.iEN   = v.en;
      if (v.req) exp0.push_back(v.addr);
    end else begin
      b1.iADDR = v.addr;
      b1.iEN   = v.en;
      if (v.req) exp1.push_back(v.addr);
      if (v.ls) expLs1.push_back(v.addr);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic hsStep(input logic [9:0] a, input logic ack, input logic clr, input logic expPush);
    b2.iADDR    = a;
    b2.iACK     = ack;
    b2.iCLR_OVF = clr;
    if (expPush) exp2.push_back(a);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v0[10];
    vec_t v1[12];
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    b0.iEN = 1'b1; b0.iADDR = 10'd0; b0.iACK = 1'b0; b0.iCLR_OVF = 1'b0;
    b1.iEN = 1'b1; b1.iADDR = 10'd0; b1.iACK = 1'b0; b1.iCLR_OVF = 1'b0;
    b2.iEN = 1'b1; b2.iADDR = 10'd0; b2.iACK = 1'b0; b2.iCLR_OVF = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    chk("reset u0 oREQ", 32'(b0.oREQ), 32'd0);
    chk("reset u0 oREQ_ADDR", 32'(b0.oREQ_ADDR), 32'd0);
    chk("reset u0 oPEND", 32'(b0.oPEND), 32'd0);
    chk("reset u1 oLINE_START", 32'(b1.oLINE_START), 32'd0);
    chk("reset u2 oREQ", 32'(b2.oREQ), 32'd0);
    chk("reset u2 oPEND", 32'(b2.oPEND), 32'd0);
    chk("reset u2 oOVF", 32'(b2.oOVF), 32'd0);

    // pulse DIV=1: 0->5->6->6->7, then iEN gating 3,4,5 off, 5 on, 6 on
    v0 = '{'{10'd5, 1'b1, 1'b1, 1'b0}, '{10'd6, 1'b1, 1'b1, 1'b0},
           '{10'd6, 1'b1, 1'b0, 1'b0}, '{10'd7, 1'b1, 1'b1, 1'b0},
           '{10'd3, 1'b0, 1'b0, 1'b0}, '{10'd4, 1'b0, 1'b0, 1'b0},
           '{10'd5, 1'b0, 1'b0, 1'b0}, '{10'd5, 1'b1, 1'b0, 1'b0},
           '{10'd6, 1'b1, 1'b1, 1'b0}, '{10'd6, 1'b1, 1'b0, 1'b0}};
    foreach (v0[i]) pulseVec(0, v0[i]);
    b0.iEN = 1'b0;

    // pulse DIV=3: 1..10 then wrap to 0
    v1 = '{'{10'd1, 1'b1, 1'b1, 1'b0}, '{10'd2, 1'b1, 1'b0, 1'b0},
           '{10'd3, 1'b1, 1'b0, 1'b0}, '{10'd4, 1'b1, 1'b1, 1'b0},
           '{10'd5, 1'b1, 1'b0, 1'b0}, '{10'd6, 1'b1, 1'b0, 1'b0},
           '{10'd7, 1'b1, 1'b1, 1'b0}, '{10'd8, 1'b1, 1'b0, 1'b0},
           '{10'd9, 1'b1, 1'b0, 1'b0}, '{10'd10, 1'b1, 1'b1, 1'b0},
           '{10'd0, 1'b1, 1'b1, 1'b1}, '{10'd0, 1'b1, 1'b0, 1'b0}};
    foreach (v1[i]) pulseVec(1, v1[i]);
    b1.iEN = 1'b0;
    chk("u0 queue left", 32'(exp0.size()), 32'd0);
    chk("u1 queue left", 32'(exp1.size()), 32'd0);
    chk("u1 line-start left", 32'(expLs1.size()), 32'd0);

    // queued: fill 1..4, 5 overflows
    for (int a = 1; a <= 5; a++) begin
      hsStep(10'(a), 1'b0, 1'b0, (a <= 4) ? 1'b1 : 1'b0);
      chk("u2 fill oPEND", 32'(b2.oPEND), 32'((a <= 4) ? a : 4));
      chk("u2 fill head", 32'(b2.oREQ_ADDR), 32'd1);
    end
    chk("u2 overflow", 32'(b2.oOVF), 32'd1);
    // drain with iACK
    for (int k = 1; k <= 4; k++) begin
      hsStep(10'd5, 1'b1, 1'b0, 1'b0);
      chk("u2 drain oPEND", 32'(b2.oPEND), 32'(4 - k));
    end
    b2.iACK = 1'b0;
    chk("u2 drained oREQ", 32'(b2.oREQ), 32'd0);
    hsStep(10'd5, 1'b0, 1'b1, 1'b0);
    chk("u2 clear oOVF", 32'(b2.oOVF), 32'd0);

    // full queue: pop and push together
    for (int a = 6; a <= 9; a++) hsStep(10'(a), 1'b0, 1'b0, 1'b1);
    chk("u2 refill oPEND", 32'(b2.oPEND), 32'd4);
    hsStep(10'd10, 1'b1, 1'b0, 1'b1);
    chk("u2 full push+pop oPEND", 32'(b2.oPEND), 32'd4);
    chk("u2 full push+pop oOVF", 32'(b2.oOVF), 32'd0);
    chk("u2 full push+pop head", 32'(b2.oREQ_ADDR), 32'd7);
    // overflow together with clear: set wins
    hsStep(10'd11, 1'b0, 1'b1, 1'b0);
    chk("u2 set beats clear", 32'(b2.oOVF), 32'd1);
    chk("u2 overflow oPEND", 32'(b2.oPEND), 32'd4);
    hsStep(10'd11, 1'b1, 1'b0, 1'b0);
    b2.iACK = 1'b0;
    chk("u2 pre-reset oPEND", 32'(b2.oPEND), 32'd3);
    chk("u2 pre-reset head", 32'(b2.oREQ_ADDR), 32'd8);

    // reset mid-queue discards everything
    rst = 1'b1;
    exp2.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("u2 mid-reset oREQ", 32'(b2.oREQ), 32'd0);
    chk("u2 mid-reset oPEND", 32'(b2.oPEND), 32'd0);
    chk("u2 mid-reset oOVF", 32'(b2.oOVF), 32'd0);
    chk("u2 mid-reset oREQ_ADDR", 32'(b2.oREQ_ADDR), 32'd0);
    hsStep(10'd12, 1'b0, 1'b0, 1'b1);
    chk("u2 post-reset oPEND", 32'(b2.oPEND), 32'd1);
    chk("u2 post-reset head", 32'(b2.oREQ_ADDR), 32'd12);
    hsStep(10'd12, 1'b1, 1'b0, 1'b0);
    b2.iACK = 1'b0;
    chk("u2 final oPEND", 32'(b2.oPEND), 32'd0);

    repeat (2) @(posedge clk);
    #1;
    chk("u2 queue left", 32'(exp2.size()), 32'd0);
    chk("u0 queue left end", 32'(exp0.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
